// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write/read IP: FSM state encoding,
// default frame width and the fixed SPI mode.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4
  } spi_state_e;

  localparam int DefaultDataWidth = 16;

  // Mode 0 only; the read block uses these to stay consistent with the writer.
  localparam logic SpiCpol = 1'b0;
  localparam logic SpiCpha = 1'b0;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, shift-left register for the SPI transmit path; the MSB
// is the bit currently presented on MOSI.
module spi_shift_reg #(
  parameter int Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             msb_o
);

  logic [Width-1:0] shreg_q;
  logic [Width-1:0] shreg_d;

  // Clearing at end of frame returns MOSI to 0 while idle.
  always_comb begin
    // NOTE: default assignment first so every path assigns shreg_d (no latch).
    shreg_d = shreg_q;
    if (clear_i) begin
      shreg_d = '0;
    end else if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments for all flop updates to avoid ordering races.
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[Width-1];

endmodule

// File: rtl/spi_write_ctrl.sv
// SPI mode-0 write master: serialises one word MSB-first per start request,
// advancing one half-period per divider tick and gating the divider via div_en_o.
module spi_write_ctrl
  import spi_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int CntWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 tick_i,
  output logic                 div_en_o,
  output logic                 sclk_o,
  output logic                 mosi_o,
  output logic                 cs_no,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [CntWidth-1:0] LastBit = CntWidth'(DataWidth - 1);

  spi_state_e          state_q, state_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                load, shift, clear;
  logic                msb;

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
        end
      end
      SETUP: begin
        if (tick_i) begin
          state_d = SCLK_HI;
          sclk_d  = 1'b1;
        end
      end
      SCLK_HI: begin
        if (tick_i) begin
          sclk_d = 1'b0;
          if (cnt_q == LastBit) begin
            state_d = HOLD;
          end else begin
            // MOSI advances on the falling edge so it is stable at the next rise.
            state_d = SCLK_LO;
            shift   = 1'b1;
            cnt_d   = cnt_q + CntWidth'(1);
          end
        end
      end
      SCLK_LO: begin
        if (tick_i) begin
          state_d = SCLK_HI;
          sclk_d  = 1'b1;
        end
      end
      HOLD: begin
        if (tick_i) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  spi_shift_reg #(
    .Width(DataWidth)
  ) u_shift_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .shift_i(shift),
    .clear_i(clear),
    .data_i (data_i),
    .msb_o  (msb)
  );

  assign sclk_o   = sclk_q;
  assign mosi_o   = msb;
  assign cs_no    = cs_n_q;
  assign busy_o   = busy_q;
  assign div_en_o = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_spi_write_ctrl.sv
// Self-checking bench for spi_write_ctrl (8-bit frames) with an enable-gated
// tick divider model and a bus monitor that records what a slave would sample.
module tb_spi_write_ctrl;

  localparam int DW = 8;
  localparam int FrameTicks = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          tick_i = 1'b0;
  logic          div_en_o, sclk_o, mosi_o, cs_no, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  int period = 4;
  bit stall = 1'b0;
  int div_cnt = 0;

  bit   bits[$];
  int   cs_low, done_cnt, ticks, mosi_viol, couple_viol;
  logic sclk_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b0;

  spi_write_ctrl #(
    .DataWidth(DW),
    .CntWidth (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_i),
    .data_i  (data_i),
    .tick_i  (tick_i),
    .div_en_o(div_en_o),
    .sclk_o  (sclk_o),
    .mosi_o  (mosi_o),
    .cs_no   (cs_no),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Divider model: counts only while enabled, random noise on tick_i while idle.
  initial forever begin
    @(posedge clk);
    #1;
    if (div_en_o !== 1'b1) begin
      div_cnt = 0;
      tick_i  = 1'($urandom_range(0, 1));
    end else if (stall) begin
      tick_i = 1'b0;
    end else begin
      tick_i  = (div_cnt == period - 1);
      div_cnt = (div_cnt == period - 1) ? 0 : div_cnt + 1;
    end
  end

  // Slave-side view: bits captured on each SCLK rise plus protocol counters.
  always @(negedge clk) begin
    if (sclk_o === 1'b1 && sclk_prev === 1'b0) bits.push_back(mosi_o);
    if (mosi_o !== mosi_prev && !(sclk_prev === 1'b1 && sclk_o === 1'b0) && cs_prev === cs_no)
      mosi_viol++;
    if (cs_no === 1'b0) cs_low++;
    if (busy_o !== ~cs_no || div_en_o !== busy_o) couple_viol++;
    if (busy_o === 1'b1 && tick_i === 1'b1) ticks++;
    if (done_o === 1'b1) done_cnt++;
    sclk_prev = sclk_o;
    cs_prev   = cs_no;
    mosi_prev = mosi_o;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits.delete();
    cs_low      = 0;
    done_cnt    = 0;
    ticks       = 0;
    mosi_viol   = 0;
    couple_viol = 0;
  endtask

  function automatic int unsigned bits_val();
    int unsigned v = 0;
    foreach (bits[i]) v = (v << 1) | 32'(bits[i]);
    return v;
  endfunction

  task automatic start_frame(input logic [DW-1:0] d);
    data_i  = d;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    data_i  = DW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL wait_done: no done_o within %0d clocks", budget);
    end
    step();
    step();
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (bits.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (bits.size() < n) begin
      errors++;
      $display("FAIL wait_bits: saw %0d rising edges, wanted %0d", bits.size(), n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({sclk_o, mosi_o, cs_no, busy_o, div_en_o, done_o} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs: sclk/mosi/cs_n/busy/div_en/done=%b want 001000",
               {sclk_o, mosi_o, cs_no, busy_o, div_en_o, done_o});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_enable();
    int bad = 0;
    logic [DW-1:0] d = DW'($urandom);
    clear_mon();
    repeat (50) begin
      step();
      if (div_en_o !== 1'b0 || busy_o !== 1'b0 || cs_no !== 1'b1 || sclk_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, %0d done pulses, want 0/0", bad, done_cnt);
    end
    period = $urandom_range(2, 5);
    start_frame(d);
    checks++;
    if ({div_en_o, busy_o, cs_no, sclk_o, mosi_o} !== {4'b1100, d[DW-1]}) begin
      errors++;
      $display("FAIL accept_outputs: div_en/busy/cs_n/sclk/mosi=%b want %b",
               {div_en_o, busy_o, cs_no, sclk_o, mosi_o}, {4'b1100, d[DW-1]});
    end
    wait_done(period * FrameTicks + 20);
    checks++;
    if (bits.size() != DW || bits_val() != 32'(d)) begin
      errors++;
      $display("FAIL idle_frame_bits: got %0h (%0d bits) want %0h", bits_val(), bits.size(), d);
    end
  endtask

  task automatic test_basic();
    period = 4;
    clear_mon();
    start_frame(8'hA5);
    wait_done(200);
    checks++;
    if (bits.size() != DW || bits_val() != 32'hA5) begin
      errors++;
      $display("FAIL basic_bits: got %0h (%0d bits) want a5", bits_val(), bits.size());
    end
    checks++;
    if (cs_low != 68) begin
      errors++;
      $display("FAIL basic_cs_low: got %0d clocks want 68", cs_low);
    end
    checks++;
    if (done_cnt != 1 || ticks != FrameTicks) begin
      errors++;
      $display("FAIL basic_done_ticks: done=%0d ticks=%0d want 1/%0d", done_cnt, ticks, FrameTicks);
    end
    checks++;
    if (mosi_viol != 0 || couple_viol != 0 || cs_no !== 1'b1) begin
      errors++;
      $display("FAIL basic_protocol: mosi_viol=%0d couple_viol=%0d cs_n=%b want 0/0/1",
               mosi_viol, couple_viol, cs_no);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      period = $urandom_range(1, 5);
      clear_mon();
      start_frame(d);
      wait_done(period * FrameTicks + 20);
      checks++;
      if (bits.size() != DW || bits_val() != 32'(d) || cs_low != period * FrameTicks ||
          done_cnt != 1 || ticks != FrameTicks || mosi_viol != 0 || couple_viol != 0) begin
        errors++;
        $display("FAIL random_frame[%0d]: bits=%0h/%0d cs_low=%0d done=%0d ticks=%0d viol=%0d/%0d want %0h/%0d %0d 1 %0d 0/0",
                 i, bits_val(), bits.size(), cs_low, done_cnt, ticks, mosi_viol, couple_viol,
                 d, DW, period * FrameTicks, FrameTicks);
      end
    end
  endtask

  task automatic test_start_while_busy();
    period = $urandom_range(2, 4);
    clear_mon();
    start_frame(8'hA5);
    wait_bits(3, 200);
    data_i  = 8'h3C;
    start_i = 1'b1;
    repeat (5) step();
    start_i = 1'b0;
    wait_done(period * FrameTicks + 20);
    repeat (10) step();
    checks++;
    if (bits.size() != DW || bits_val() != 32'hA5) begin
      errors++;
      $display("FAIL busy_start_bits: got %0h (%0d bits) want a5", bits_val(), bits.size());
    end
    checks++;
    if (done_cnt != 1 || cs_no !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_single: done=%0d cs_n=%b busy=%b want 1/1/0", done_cnt, cs_no, busy_o);
    end
  endtask

  task automatic test_start_at_done();
    int k = 0;
    logic [DW-1:0] d = DW'($urandom);
    period = $urandom_range(2, 4);
    clear_mon();
    start_frame(d);
    while (!(bits.size() == DW && sclk_o === 1'b0 && tick_i === 1'b1) && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL done_start_reach: final hold tick not seen, %0d edges", bits.size());
    end
    start_i = 1'b1;
    data_i  = DW'($urandom);
    step();
    start_i = 1'b0;
    step();
    step();
    checks++;
    if (cs_no !== 1'b1 || busy_o !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL done_start_ignored: cs_n=%b busy=%b done=%0d want 1/0/1", cs_no, busy_o, done_cnt);
    end
    checks++;
    if (bits.size() != DW || bits_val() != 32'(d)) begin
      errors++;
      $display("FAIL done_start_bits: got %0h (%0d bits) want %0h", bits_val(), bits.size(), d);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    period = $urandom_range(1, 4);
    clear_mon();
    start_frame(8'hFF);
    while (done_cnt == 0 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (done_cnt != 1 || cs_no !== 1'b1 || bits_val() != 32'hFF || bits.size() != DW) begin
      errors++;
      $display("FAIL b2b_first: done=%0d cs_n=%b bits=%0h/%0d want 1/1/ff/%0d",
               done_cnt, cs_no, bits_val(), bits.size(), DW);
    end
    clear_mon();
    start_frame(8'h00);
    checks++;
    if (cs_no !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_start: cs_n=%b busy=%b want 0/1", cs_no, busy_o);
    end
    wait_done(period * FrameTicks + 20);
    checks++;
    if (bits.size() != DW || bits_val() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_second_bits: got %0h (%0d bits) done=%0d want 0/%0d/1",
               bits_val(), bits.size(), done_cnt, DW);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d = DW'($urandom);
    period = $urandom_range(2, 4);
    clear_mon();
    start_frame(DW'($urandom));
    wait_bits(3, 200);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_no, sclk_o, busy_o, div_en_o, mosi_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_async: cs_n/sclk/busy/div_en/mosi=%b want 10000",
               {cs_no, sclk_o, busy_o, div_en_o, mosi_o});
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d done pulses want 0", done_cnt);
    end
    clear_mon();
    start_frame(d);
    wait_done(period * FrameTicks + 20);
    checks++;
    if (bits.size() != DW || bits_val() != 32'(d) || done_cnt != 1 || cs_low != period * FrameTicks) begin
      errors++;
      $display("FAIL reset_mid_next: bits=%0h/%0d done=%0d cs_low=%0d want %0h/%0d 1 %0d",
               bits_val(), bits.size(), done_cnt, cs_low, d, DW, period * FrameTicks);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int bad = 0;
    logic saved;
    logic [DW-1:0] d = DW'($urandom);
    period = 4;
    clear_mon();
    start_frame(d);
    while (!(bits.size() == 4 && sclk_o === 1'b1 && tick_i === 1'b0) && k < 200) begin
      step();
      k++;
    end
    stall = 1'b1;
    saved = mosi_o;
    repeat (100) begin
      step();
      if (sclk_o !== 1'b1 || mosi_o !== saved) bad++;
    end
    stall = 1'b0;
    checks++;
    if (k >= 200 || bad != 0) begin
      errors++;
      $display("FAIL stall_hold: reach=%0d unstable_cycles=%0d want <200/0", k, bad);
    end
    wait_done(400);
    checks++;
    if (bits.size() != DW || bits_val() != 32'(d) || done_cnt != 1 || ticks != FrameTicks ||
        cs_low != 4 * FrameTicks + 100 || mosi_viol != 0) begin
      errors++;
      $display("FAIL stall_resume: bits=%0h/%0d done=%0d ticks=%0d cs_low=%0d mviol=%0d want %0h/%0d 1 %0d %0d 0",
               bits_val(), bits.size(), done_cnt, ticks, cs_low, mosi_viol,
               d, DW, FrameTicks, 4 * FrameTicks + 100);
    end
  endtask

  initial begin
    test_reset();
    test_idle_enable();
    test_basic();
    test_random();
    test_start_while_busy();
    test_start_at_done();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
